// File: rtl/fs_accel_iload_ctrl_if.sv
// fs_accel_iload_ctrl_if
//   Bundles the job configuration, input line buffer read port, input demux
//   and window write strobes, and the PE acknowledge handshake for the 3x3 PE
//   input window loader.
//   master : the load controller (drives status, buffer reads, window writes)
//   slave  : the surrounding system (drives start, configuration, win_ack)
interface fs_accel_iload_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [ADDR_W-1:0] cfg_row_stride;
  logic [CNT_W-1:0]  cfg_num_win;
  logic              busy;
  logic              done;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [1:0]        idemux_sel;
  logic              win_we;
  logic              win_valid;
  logic              win_ack;
  logic [15:0]       perf_stall_cnt;

  modport master (
    input  start, cfg_base_addr, cfg_row_stride, cfg_num_win, win_ack,
    output busy, done, buf_rd_en, buf_rd_addr, idemux_sel, win_we,
           win_valid, perf_stall_cnt
  );

  modport slave (
    output start, cfg_base_addr, cfg_row_stride, cfg_num_win, win_ack,
    input  busy, done, buf_rd_en, buf_rd_addr, idemux_sel, win_we,
           win_valid, perf_stall_cnt
  );
endinterface

// File: rtl/fs_accel_iload_ctrl.sv
// fs_accel_iload_ctrl
//   Sequencer for the 3-row input demux feeding the 3x3 PE input window.
//   Per window it issues 3 row reads (base + r*stride) to the input line
//   buffer, steers each returned row (1-cycle read latency) to window row
//   0/1/2 via idemux_sel + win_we, then holds win_valid until win_ack.
//   After each ack the base slides one column (+1) until cfg_num_win windows
//   are done, then a one-cycle done pulse is emitted.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fs_accel_iload_ctrl_if.master (start/cfg in, busy/done,
//              buffer read, demux select, window strobes, win_ack, perf)
// Build option:
//   FS_ACCEL_ILOAD_PERF_EN - when defined, perf_stall_cnt counts cycles spent
//   waiting for win_ack (saturating, cleared on accepted start and rst);
//   otherwise it is tied to zero.
module fs_accel_iload_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  fs_accel_iload_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_PE, FIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        r_q, r_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    base_d   = base_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    valid_d  = valid_q;
    // Write side is the read side delayed by the buffer's 1-cycle latency;
    // the select holds its last row between bursts.
    we_d     = rd_en_q;
    sel_d    = rd_en_q ? r_q : sel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d   = bus.cfg_base_addr;
          stride_d = bus.cfg_row_stride;
          rem_d    = bus.cfg_num_win;
          busy_d   = 1'b1;
          if (bus.cfg_num_win != '0) begin
            state_d = ISSUE;
            rd_en_d = 1'b1;
            addr_d  = bus.cfg_base_addr;
            r_d     = 2'd0;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        if (r_q == 2'd2) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          r_d     = r_q + 2'd1;
          addr_d  = addr_q + stride_q;
        end
      end
      DRAIN: begin
        // Last row is written this cycle, so the window is complete next.
        state_d = WAIT_PE;
        valid_d = 1'b1;
      end
      WAIT_PE: begin
        if (bus.win_ack) begin
          valid_d = 1'b0;
          rem_d   = rem_q - CNT_W'(1);
          base_d  = base_q + ADDR_W'(1);
          if (rem_q > CNT_W'(1)) begin
            state_d = ISSUE;
            rd_en_d = 1'b1;
            addr_d  = base_q + ADDR_W'(1);
            r_d     = 2'd0;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      valid_q <= valid_d;
    end
  end

  // Latched job configuration is only meaningful while busy.
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    stride_q <= stride_d;
  end

`ifdef FS_ACCEL_ILOAD_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start) begin
      stall_d = '0;
    end else if (state_q == WAIT_PE && !bus.win_ack && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign bus.perf_stall_cnt = stall_q;
`else
  assign bus.perf_stall_cnt = 16'd0;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.buf_rd_en   = rd_en_q;
  assign bus.buf_rd_addr = addr_q;
  assign bus.idemux_sel  = sel_q;
  assign bus.win_we      = we_q;
  assign bus.win_valid   = valid_q;

endmodule

// File: tb/tb_fs_accel_iload_ctrl.sv
// tb_fs_accel_iload_ctrl
//   Directed bench for the input window load sequencer. Cycle T is the cycle
//   in which start is sampled; outputs are sampled on the falling edge.
module tb_fs_accel_iload_ctrl;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
`ifdef FS_ACCEL_ILOAD_PERF_EN
  localparam int PERF_STALL_EXP = 10;
`else
  localparam int PERF_STALL_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fs_accel_iload_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  fs_accel_iload_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench sampling in cycle T+1.
  task automatic start_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                           input logic [CNT_W-1:0] num);
    @(negedge clk);
    bus.cfg_base_addr  = base;
    bus.cfg_row_stride = stride;
    bus.cfg_num_win    = num;
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic single_window(input string tag);
    bus.win_ack = 1'b0;
    start_job(10'h010, 10'h020, 8'd1);
    chk({tag, "_t1_busy"}, bus.busy, 1);
    chk({tag, "_t1_rd_en"}, bus.buf_rd_en, 1);
    chk({tag, "_t1_addr"}, bus.buf_rd_addr, 32'h010);
    chk({tag, "_t1_we"}, bus.win_we, 0);
    @(negedge clk);
    chk({tag, "_t2_addr"}, bus.buf_rd_addr, 32'h030);
    chk({tag, "_t2_we_sel"}, {bus.win_we, bus.idemux_sel}, {1'b1, 2'd0});
    @(negedge clk);
    chk({tag, "_t3_addr"}, bus.buf_rd_addr, 32'h050);
    chk({tag, "_t3_rd_en"}, bus.buf_rd_en, 1);
    chk({tag, "_t3_we_sel"}, {bus.win_we, bus.idemux_sel}, {1'b1, 2'd1});
    @(negedge clk);
    chk({tag, "_t4_rd_en"}, bus.buf_rd_en, 0);
    chk({tag, "_t4_we_sel"}, {bus.win_we, bus.idemux_sel}, {1'b1, 2'd2});
    chk({tag, "_t4_valid"}, bus.win_valid, 0);
    @(negedge clk);
    chk({tag, "_t5_valid"}, bus.win_valid, 1);
    chk({tag, "_t5_we_sel_hold"}, {bus.win_we, bus.idemux_sel}, {1'b0, 2'd2});
    bus.win_ack = 1'b1;
    @(negedge clk);
    bus.win_ack = 1'b0;
    chk({tag, "_t6_valid"}, bus.win_valid, 0);
    chk({tag, "_t6_busy_done"}, {bus.busy, bus.done}, {1'b1, 1'b0});
    @(negedge clk);
    chk({tag, "_t7_busy_done"}, {bus.busy, bus.done}, {1'b0, 1'b1});
    @(negedge clk);
    chk({tag, "_t8_done"}, bus.done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] addrs[$];
    logic [ADDR_W-1:0] slide_exp [9];
    int dn, dcyc, rdn, held, bz;

    slide_exp = '{10'h010, 10'h030, 10'h050, 10'h011, 10'h031, 10'h051,
                  10'h012, 10'h032, 10'h052};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.win_ack = 1'b0;
    bus.cfg_base_addr = '0;
    bus.cfg_row_stride = '0;
    bus.cfg_num_win = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.busy, bus.done, bus.buf_rd_en, bus.win_we, bus.win_valid}, 0);
    chk("rst_addr", bus.buf_rd_addr, 0);
    chk("rst_sel", bus.idemux_sel, 0);
    chk("rst_perf", bus.perf_stall_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single window
    single_window("sw");

    // Slide over 3 windows with ack held high
    bus.win_ack = 1'b1;
    start_job(10'h010, 10'h020, 8'd3);
    addrs.delete();
    dn = 0; dcyc = 0;
    for (int k = 1; k <= 25; k++) begin
      if (bus.buf_rd_en) addrs.push_back(bus.buf_rd_addr);
      if (bus.done) begin dn++; dcyc = k; end
      @(negedge clk);
    end
    bus.win_ack = 1'b0;
    chk("slide_nreads", addrs.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < addrs.size()) chk($sformatf("slide_addr%0d", i), addrs[i], slide_exp[i]);
    chk("slide_done_count", dn, 1);
    chk("slide_done_cycle", dcyc, 17);

    // Zero windows
    start_job(10'h100, 10'h001, 8'd0);
    rdn = 0; dcyc = 0; bz = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.buf_rd_en) rdn++;
      if (bus.done) dcyc = k;
      if (k == 2) bz = bus.busy;
      @(negedge clk);
    end
    chk("zero_rd_count", rdn, 0);
    chk("zero_done_cycle", dcyc, 2);
    chk("zero_busy_at_done", bz, 0);

    // Address wrap
    bus.win_ack = 1'b1;
    start_job(10'h3FF, 10'h001, 8'd1);
    addrs.delete();
    dcyc = 0;
    for (int k = 1; k <= 9; k++) begin
      if (bus.buf_rd_en) addrs.push_back(bus.buf_rd_addr);
      if (bus.done) dcyc = k;
      @(negedge clk);
    end
    bus.win_ack = 1'b0;
    chk("wrap_nreads", addrs.size(), 3);
    if (addrs.size() == 3) begin
      chk("wrap_addr0", addrs[0], 32'h3FF);
      chk("wrap_addr1", addrs[1], 32'h000);
      chk("wrap_addr2", addrs[2], 32'h001);
    end
    chk("wrap_done_cycle", dcyc, 7);

    // Stall with an ignored start during WAIT_PE
    start_job(10'h040, 10'h008, 8'd1);
    for (int n = 0; n < 20 && !bus.win_valid; n++) @(negedge clk);
    chk("stall_valid_seen", bus.win_valid, 1);
    held = 0; rdn = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.win_valid) held++;
      if (bus.buf_rd_en) rdn++;
      bus.start = (i == 3);
      bus.cfg_base_addr = 10'h200;
      bus.cfg_num_win = 8'd5;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("stall_valid_held", held, 10);
    chk("stall_no_reads", rdn, 0);
    chk("stall_perf_cnt", bus.perf_stall_cnt, PERF_STALL_EXP);
    chk("stall_valid_still", bus.win_valid, 1);
    bus.win_ack = 1'b1;
    @(negedge clk);
    bus.win_ack = 1'b0;
    dn = 0; bz = 0; rdn = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) dn++;
      if (k >= 2 && bus.busy) bz++;
      if (bus.buf_rd_en) rdn++;
      @(negedge clk);
    end
    chk("stall_done_count", dn, 1);
    chk("stall_start_ignored_busy", bz, 0);
    chk("stall_start_ignored_rd", rdn, 0);

    // Reset in the middle of ISSUE
    start_job(10'h010, 10'h020, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", {bus.busy, bus.done, bus.buf_rd_en, bus.win_we, bus.win_valid}, 0);
    chk("midrst_addr_sel", {bus.buf_rd_addr, bus.idemux_sel}, 0);
    chk("midrst_perf", bus.perf_stall_cnt, 0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done || bus.busy || bus.buf_rd_en) dn++;
      @(negedge clk);
    end
    chk("midrst_quiet", dn, 0);
    single_window("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
